// File: rtl/cmp_sched_pkg.sv
// Shared definitions for the shared 2-bit comparator scheduler:
// FSM state encoding, digit width and the digit-count helper.
package cmp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 2;

    // Number of 2-bit digits in a WIDTH-bit operand.
    function automatic int ndig_of(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Purely combinational 2-bit unsigned magnitude comparator. This is the
// single shared comparator resource; exactly one instance exists.
module cmp2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt,
    output logic       lt,
    output logic       eq
);

    // One-hot unsigned comparison of one digit.
    always_comb begin
        gt = (a > b);
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/shared_compare_sched.sv
// Round-robin scheduler that serialises WIDTH-bit unsigned comparisons from
// two requesters through one shared 2-bit comparator slice, MSB digit first.
// Optional build macro SHARED_COMPARE_SCHED_EARLY_EXIT_EN: when defined the
// scan stops at the first differing digit; otherwise all digits are always
// scanned (constant latency) and the first differing digit decides.
module shared_compare_sched
    import cmp_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_gt,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_id
);

    localparam int NDIG  = ndig_of(WIDTH);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             state_q, state_d;
    logic               pref_q, pref_d;      // requester favoured on a tie
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               id_q, id_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
`ifndef SHARED_COMPARE_SCHED_EARLY_EXIT_EN
    logic               found_q, found_d;    // a differing digit was already seen
`endif

    logic               grant0, grant1, accept, run_last;
    logic [1:0]         dig_a, dig_b;
    logic               slc_gt, slc_lt, slc_eq;

    // Current digit of the latched operands feeds the shared slice.
    assign dig_a = a_q[{idx_q, 1'b0} +: DIGIT_W];
    assign dig_b = b_q[{idx_q, 1'b0} +: DIGIT_W];

    cmp2_slice u_slice (
        .a  (dig_a),
        .b  (dig_b),
        .gt (slc_gt),
        .lt (slc_lt),
        .eq (slc_eq)
    );

`ifdef SHARED_COMPARE_SCHED_EARLY_EXIT_EN
    assign run_last = !slc_eq || (idx_q == '0);
`else
    assign run_last = (idx_q == '0);
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (run_last)  state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM outputs: round-robin grant, request readies and result valid.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || !pref_q);
        grant1     = req1_valid && (!req0_valid ||  pref_q);
        req0_ready = !rst && (state_q == IDLE) && grant0;
        req1_ready = !rst && (state_q == IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        res_valid  = (state_q == DONE);
    end

    // Datapath next values: operand capture, digit walk and result capture.
    always_comb begin
        pref_d = pref_q;
        a_d    = a_q;
        b_d    = b_q;
        id_d   = id_q;
        idx_d  = idx_q;
        gt_d   = gt_q;
        lt_d   = lt_q;
        eq_d   = eq_q;
`ifndef SHARED_COMPARE_SCHED_EARLY_EXIT_EN
        found_d = found_q;
`endif
        if (accept) begin
            a_d    = req1_ready ? req1_a : req0_a;
            b_d    = req1_ready ? req1_b : req0_b;
            id_d   = req1_ready;
            pref_d = req0_ready;             // favour the other side next tie
            idx_d  = IDX_W'(NDIG - 1);
`ifndef SHARED_COMPARE_SCHED_EARLY_EXIT_EN
            found_d = 1'b0;
`endif
        end else if (state_q == RUN) begin
`ifdef SHARED_COMPARE_SCHED_EARLY_EXIT_EN
            if (run_last) begin
                gt_d = slc_gt;
                lt_d = slc_lt;
                eq_d = slc_eq;
            end
`else
            // Track the slice until the first differing digit, then freeze.
            if (!found_q) begin
                gt_d = slc_gt;
                lt_d = slc_lt;
                eq_d = slc_eq;
            end
            found_d = found_q || !slc_eq;
`endif
            if (!run_last) idx_d = idx_q - 1'b1;
        end
    end

    // Datapath registers; result and control bits clear on reset.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        idx_q <= idx_d;
        if (rst) begin
            pref_q <= 1'b0;
            id_q   <= 1'b0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else begin
            pref_q <= pref_d;
            id_q   <= id_d;
            gt_q   <= gt_d;
            lt_q   <= lt_d;
            eq_q   <= eq_d;
        end
    end

`ifndef SHARED_COMPARE_SCHED_EARLY_EXIT_EN
    // Differing-digit flag for the constant-time scan.
    always_ff @(posedge clk) begin
        if (rst) found_q <= 1'b0;
        else     found_q <= found_d;
    end
`endif

    assign res_gt = gt_q;
    assign res_lt = lt_q;
    assign res_eq = eq_q;
    assign res_id = id_q;

endmodule
